// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: divides clk to a 1 Hz count enable and keeps mm:ss (each 0-59)
//   under start/stop and clear control. start_stop rising edges toggle counting; clear
//   forces 00:00 and stops. Ports: clk, reset (sync, active-high), start_stop, clear in;
//   seconds_bin, minuts_bcd (binary 0-59), running, tick, rollover out (all registered).
// Latency: control inputs take effect on the next edge; counts update one edge after
//   the last prescaler cycle of a second.
// Backpressure: none; free-running counter with no handshake.
module stopwatch_time_counter #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [5:0] seconds_bin,
  output logic [5:0] minuts_bcd,
  output logic       running,
  output logic       tick,
  output logic       rollover
);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [5:0]       UNIT_LAST = 6'd59;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ss_d;
  logic             rise;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt;
  logic [5:0]       sec_nxt;
  logic [5:0]       min_nxt;
  logic             step_sec;
  logic             sec_wrap;
  logic             min_wrap;

  // Button history is sampled even during reset, so a button held through
  // reset never looks like a fresh press afterwards.
  always_ff @(posedge clk) begin
    ss_d <= start_stop;
  end

  assign rise = start_stop & ~ss_d;

  // Next-state logic: clear wins over a same-cycle button edge.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (rise) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = HOLD;
        HOLD:    state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The registered state alone gates the increment, so a stop request that lands
  // on the last prescaler cycle still lets that second be counted.
  always_comb begin
    step_sec = (state == RUN) && (pre == PRE_LAST) && !clear;
    sec_wrap = (seconds_bin == UNIT_LAST);
    min_wrap = (minuts_bcd == UNIT_LAST);
  end

  // Prescaler only advances in RUN; in HOLD it keeps the fractional second.
  always_comb begin
    pre_nxt = pre;
    if (clear) begin
      pre_nxt = '0;
    end else if (state == RUN) begin
      if (pre == PRE_LAST) begin
        pre_nxt = '0;
      end else begin
        pre_nxt = pre + PRE_W'(1);
      end
    end
  end

  // Time counters: seconds carry into minutes, and 59:59 wraps to 00:00.
  always_comb begin
    sec_nxt = seconds_bin;
    min_nxt = minuts_bcd;
    if (clear) begin
      sec_nxt = '0;
      min_nxt = '0;
    end else if (step_sec) begin
      if (sec_wrap) begin
        sec_nxt = '0;
        if (min_wrap) begin
          min_nxt = '0;
        end else begin
          min_nxt = minuts_bcd + 6'd1;
        end
      end else begin
        sec_nxt = seconds_bin + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pre         <= '0;
      seconds_bin <= '0;
      minuts_bcd  <= '0;
      running     <= 1'b0;
      tick        <= 1'b0;
      rollover    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pre         <= pre_nxt;
      seconds_bin <= sec_nxt;
      minuts_bcd  <= min_nxt;
      // running mirrors the registered state, so it is derived from the next state.
      running     <= (state_nxt == RUN);
      tick        <= step_sec;
      rollover    <= step_sec && sec_wrap && min_wrap;
    end
  end

endmodule

// File: doc/stopwatch_time_counter.md
# stopwatch_time_counter

Time-keeping core of the stopwatch. Divides the board clock down to a 1 Hz count enable. Counts elapsed seconds and minutes (each 0–59) under start/stop and clear control. Drives the binary minute value consumed by the minutes seven-segment decoder, plus the seconds value for the seconds decoder.

## Interface

Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per counted second (100 MHz board clock); must be ≥ 2.
- `PRE_W`, default 27: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  debounced, synchronous push-button level; each rising edge toggles counting.
- `clear`  in  1  synchronous level; while high, holds time at 00:00 and stops counting.
- `seconds_bin`  out  6  elapsed seconds, binary, 0–59.
- `minuts_bcd`  out  6  elapsed minutes, binary, 0–59; feeds the minutes decoder directly.
- `running`  out  1  high while in RUN.
- `tick`  out  1  one-cycle pulse in the first cycle a new seconds value is visible.
- `rollover`  out  1  one-cycle pulse coincident with the 59:59 → 00:00 wrap.

## Operation

- Edge detect: `ss_d` samples `start_stop` every cycle, including reset cycles. `rise = start_stop & ~ss_d`. A button held through reset therefore produces no edge.
- FSM states and transitions:
  - IDLE: cleared and stopped.
  - RUN: counting.
  - HOLD: paused, time retained.
  - IDLE --rise--> RUN; RUN --rise--> HOLD; HOLD --rise--> RUN.
  - Any state --clear--> IDLE. `clear` has priority over `rise` in the same cycle.
- Prescaler `pre`:
  - In RUN: counts 0 … TICK_DIV-1, then wraps to 0.
  - In HOLD: frozen, so the fractional second is preserved across pause and resume.
  - Zeroed by IDLE entry or by reset.
- Second increment: occurs on the clock edge where the current state is RUN and `pre == TICK_DIV-1`.
  - Seconds 0–58: `seconds_bin` += 1.
  - Seconds at 59: `seconds_bin` → 0 and `minuts_bcd` += 1.
  - At 59:59: both counters → 0, `rollover` pulses, and counting continues (no saturation).
- Gating by registered state: the current registered state alone decides whether an increment happens. If `rise` arrives in RUN in the same cycle as `pre == TICK_DIV-1`, the increment still occurs and the state moves to HOLD on that same edge.
- Output ranges: `seconds_bin` and `minuts_bcd` never exceed 59. Values 60–63 are unreachable; a comparator must not rely on them.
- `running = (state == RUN)`, registered.

## Timing

- Reset values: state = IDLE, `pre` = 0, `seconds_bin` = 0, `minuts_bcd` = 0, `running` = 0, `tick` = 0, `rollover` = 0. `ss_d` = `start_stop`.
- Control latency: `rise` sampled in cycle N puts the new state in effect from cycle N+1. `running` changes in cycle N+1.
- First increment: after entering RUN from IDLE, the first increment is visible TICK_DIV cycles after `running` rises. Subsequent increments follow every TICK_DIV RUN cycles.
- `tick` and `rollover` are registered. Each is high exactly in the cycle the updated count is visible, for one cycle.
- `clear` asserted in cycle N: all counts are 0 from N+1, and remain so while `clear` is held.
- Reset asserted mid-count: takes effect at the next edge regardless of other inputs. It overrides `clear` and `rise`.
- Outputs are glitch-free registers, so the downstream combinational decoders see stable values for a full cycle.

## Test plan

All scenarios use `TICK_DIV = 4`.

- **Reset and start:** Hold `reset` 3 cycles, then pulse `start_stop` for one cycle.
  - Required: `running` = 1 on the next cycle.
  - Required: `seconds_bin` goes 0 → 1 with `tick` = 1 exactly 4 cycles later, and increments every 4 cycles thereafter.
- **Pause preserves fraction:** Stop at `pre` = 2, wait 20 cycles, then restart.
  - Required: `seconds_bin` is unchanged during HOLD.
  - Required: the next increment arrives 2 RUN cycles after `running` returns to 1.
- **Minute carry and full wrap:** Run from 00:00 to 00:59 and hold.
  - Required: the next increment gives `seconds_bin` = 0, `minuts_bcd` = 1.
  - Continue to 59:59. Required: the next increment gives 00:00 with `rollover` = 1 and `tick` = 1 in the same cycle, and `running` stays 1.
- **Simultaneous stop and increment:** Assert `rise` in the cycle where `pre` = 3 in RUN.
  - Required: the count increments once, `running` = 0 in the next cycle, and no further increment occurs.
- **Clear priority:** Assert `clear` and `rise` together while HOLD shows 12:34.
  - Required: next cycle shows 00:00, `running` = 0, state IDLE.
  - A later single `start_stop` pulse starts counting from 00:00.
- **Button held through reset:** Keep `start_stop` high before, during and after `reset`.
  - Required: `running` stays 0; only a low-then-high transition starts counting.
